// File: rtl/development_action_pkg.sv
// Shared definitions for the development action sequencer: action/emotion bit indices,
// sequencer state encoding and the per-stage action permission mask.
package development_action_pkg;

  typedef enum int unsigned {
    ActSleep   = 0,
    ActEat     = 1,
    ActCry     = 2,
    ActPlay    = 3,
    ActExplore = 4,
    ActSpeak   = 5,
    ActLearn   = 6,
    ActRest    = 7
  } act_idx_e;

  localparam logic [7:0] ACT_REST = 8'h80;

  typedef enum int unsigned {
    EmoTired      = 0,
    EmoHungry     = 1,
    EmoDistressed = 2,
    EmoHappy      = 3,
    EmoCurious    = 4,
    EmoSocial     = 5,
    EmoFocused    = 6,
    EmoReserved   = 7
  } emo_idx_e;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StCooldown
  } state_e;

  // Actions a given development stage is allowed to perform, bits [6:0].
  function automatic logic [6:0] stage_mask(input logic [1:0] stage);
    logic [6:0] mask;
    mask = 7'b0000111;
    unique case (stage)
      2'd0:    mask = 7'b0000111;
      2'd1:    mask = 7'b0001111;
      2'd2:    mask = 7'b0111111;
      default: mask = 7'b1111111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/development_action_arbiter.sv
// One-hot arbiter over the seven action requests. Fixed priority (lowest index wins) by default;
// define ACTION_RR_EN for a round-robin search starting after the last granted index.
module action_arbiter
  import development_action_pkg::*;
(
`ifdef ACTION_RR_EN
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_grant_en,
`endif
  input  logic [6:0] i_req,
  output logic [6:0] o_grant
);

`ifdef ACTION_RR_EN
  logic [2:0] r_ptr;
  logic [2:0] w_idx;
  logic [2:0] w_pos;
  logic       w_found;

  // Search pointer+1 .. pointer+7 modulo 7, so index 6 wraps back to 0.
  always_comb begin
    o_grant = '0;
    w_idx   = r_ptr;
    w_pos   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      w_pos = 3'((32'(r_ptr) + 32'(k)) % 32'd7);
      if (!w_found && i_req[w_pos]) begin
        o_grant[w_pos] = 1'b1;
        w_idx          = w_pos;
        w_found        = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= 3'd6;
    end else if (i_grant_en) begin
      r_ptr <= w_idx;
    end
  end
`else
  // Isolate the lowest set request bit.
  always_comb begin
    o_grant = i_req & (~i_req + 7'd1);
  end
`endif

endmodule

// File: rtl/development_action_sequencer.sv
// Turns emotional drive flags into a timed one-hot action with a stage-scaled duration and a
// fixed REST cooldown. Optional macro ACTION_RR_EN selects a round-robin arbiter.
module development_action_sequencer
  import development_action_pkg::*;
#(
  parameter int unsigned DUR_BASE = 8,
  parameter int unsigned COOLDOWN = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  development_stage,
  input  logic [7:0]  emotional_state,
  input  logic [15:0] stimuli,
  output logic [7:0]  action,
  output logic        action_done,
  output logic        action_abort,
  output logic        busy
);

  state_e             r_state;
  state_e             w_state_d;
  logic [7:0]         r_action;
  logic [7:0]         w_action_d;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_d;
  logic               r_done;
  logic               w_done_d;
  logic               r_abort;
  logic               w_abort_d;

  logic [6:0]         w_mask;
  logic [6:0]         w_req;
  logic [6:0]         w_grant;
  logic               w_req_any;
  logic               w_abort_cond;
  logic               w_cnt_zero;
  logic [CNT_W-1:0]   w_dur_load;
  logic [CNT_W-1:0]   w_cd_load;
  logic               w_unused;

  assign w_mask    = stage_mask(development_stage);
  assign w_req     = emotional_state[EmoFocused:EmoTired] & w_mask;
  assign w_req_any = |w_req;
  assign w_unused  = ^{emotional_state[EmoReserved], stimuli[7:0]};

  assign w_cnt_zero = (r_cnt == '0);
  assign w_dur_load = CNT_W'(DUR_BASE * (32'(development_stage) + 32'd1) - 32'd1);
  assign w_cd_load  = CNT_W'(COOLDOWN - 32'd1);

  // CRY is immune to disturbances; a stage drop that revokes the running action always aborts.
  assign w_abort_cond = ((|stimuli[15:8]) && !r_action[ActCry]) ||
                        ((r_action[ActLearn:ActSleep] & w_mask) == '0);

`ifdef ACTION_RR_EN
  logic w_grant_en;
  assign w_grant_en = (r_state == StIdle) && w_req_any;
`endif

  action_arbiter u_arbiter (
`ifdef ACTION_RR_EN
    .i_clk      (clk),
    .i_rst      (rst),
    .i_grant_en (w_grant_en),
`endif
    .i_req      (w_req),
    .o_grant    (w_grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_action <= ACT_REST;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_abort  <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_action <= w_action_d;
      r_cnt    <= w_cnt_d;
      r_done   <= w_done_d;
      r_abort  <= w_abort_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_req_any) begin
          w_state_d = StActive;
        end
      end
      StActive: begin
        if (w_abort_cond || w_cnt_zero) begin
          w_state_d = StCooldown;
        end
      end
      StCooldown: begin
        if (w_cnt_zero) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Abort is tested before the final-cycle done so the two pulses never coincide.
  always_comb begin
    w_action_d = r_action;
    w_cnt_d    = r_cnt;
    w_done_d   = 1'b0;
    w_abort_d  = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_action_d = ACT_REST;
        if (w_req_any) begin
          w_action_d = {1'b0, w_grant};
          w_cnt_d    = w_dur_load;
        end
      end
      StActive: begin
        if (w_abort_cond) begin
          w_action_d = ACT_REST;
          w_abort_d  = 1'b1;
          w_cnt_d    = w_cd_load;
        end else if (w_cnt_zero) begin
          w_action_d = ACT_REST;
          w_done_d   = 1'b1;
          w_cnt_d    = w_cd_load;
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      StCooldown: begin
        w_action_d = ACT_REST;
        if (!w_cnt_zero) begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_action_d = ACT_REST;
        w_cnt_d    = '0;
      end
    endcase
  end

  always_comb begin
    action       = r_action;
    action_done  = r_done;
    action_abort = r_abort;
    busy         = (r_state != StIdle);
  end

endmodule
